// File: rtl/hack_boot_pkg.sv
// Shared states and constants for the Hack boot loader.
// HACK_BOOT_CHECKSUM_EN adds the trailing checksum byte and the CSUM state.
package hack_boot_pkg;

  localparam int BOOT_LEN_BYTES  = 2;
  localparam int BOOT_WORD_BYTES = 2;
  localparam int BOOT_CSUM_W     = 8;

  typedef enum logic [2:0] {
    ST_LEN_HI  = 3'd0,
    ST_LEN_LO  = 3'd1,
    ST_DATA_HI = 3'd2,
    ST_DATA_LO = 3'd3,
`ifdef HACK_BOOT_CHECKSUM_EN
    ST_CSUM    = 3'd4,
`endif
    ST_RUN     = 3'd5,
    ST_ERROR   = 3'd6
  } boot_state_e;

  function automatic logic [BOOT_CSUM_W-1:0] csum_fold(input logic [BOOT_CSUM_W-1:0] acc,
                                                        input logic [7:0]             b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/hack_boot_loader.sv
// Boot sequencer: holds the Hack CPU in reset, streams an image into the ROM, then releases.
// HACK_BOOT_CHECKSUM_EN enables the trailing XOR checksum byte.
module hack_boot_loader
  import hack_boot_pkg::*;
#(
  parameter int ROM_AW = 15
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_valid,
  output logic                         rx_ready,
  input  logic                         reboot,
  output logic                         rom_we,
  output logic [ROM_AW-1:0]            rom_addr,
  output logic [8*BOOT_WORD_BYTES-1:0] rom_wdata,
  output logic                         cpu_reset,
  output logic                         boot_done,
  output logic                         boot_error,
  output boot_state_e                  state_dbg
);

  localparam int          LEN_W     = 8 * BOOT_LEN_BYTES;
  localparam logic [31:0] MAX_WORDS = 32'd1 << ROM_AW;

  // Handshake: a byte moves on any cycle where rx_valid && rx_ready; rx_ready is
  // a pure decode of state so the sender never waits on a registered grant.
  boot_state_e       state;
  logic [7:0]        len_hi_q;
  logic [7:0]        data_hi_q;
  logic [LEN_W-1:0]  len_q;
  logic [ROM_AW:0]   idx_q;
  logic              accept;
  logic [LEN_W-1:0]  len_word;
  logic              last_word;
`ifdef HACK_BOOT_CHECKSUM_EN
  logic [BOOT_CSUM_W-1:0] csum_q;
`endif

  assign rx_ready  = (state != ST_RUN) && (state != ST_ERROR);
  assign accept    = rx_valid && rx_ready;
  assign len_word  = {len_hi_q, rx_data};
  assign last_word = (32'(idx_q) + 32'd1) == 32'(len_q);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_LEN_HI;
      len_hi_q   <= '0;
      data_hi_q  <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      rom_we     <= 1'b0;
      rom_addr   <= '0;
      rom_wdata  <= '0;
      cpu_reset  <= 1'b1;
      boot_done  <= 1'b0;
      boot_error <= 1'b0;
`ifdef HACK_BOOT_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      rom_we <= 1'b0;
      case (state)
        ST_LEN_HI: begin
          if (accept) begin
            len_hi_q <= rx_data;
            state    <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (accept) begin
            len_q <= len_word;
            if (32'(len_word) > MAX_WORDS) begin
              state      <= ST_ERROR;
              boot_error <= 1'b1;
            end else if (len_word == '0) begin
`ifdef HACK_BOOT_CHECKSUM_EN
              state <= ST_CSUM;
`else
              state     <= ST_RUN;
              boot_done <= 1'b1;
              cpu_reset <= 1'b0;
`endif
            end else begin
              state <= ST_DATA_HI;
            end
          end
        end
        ST_DATA_HI: begin
          if (accept) begin
            data_hi_q <= rx_data;
`ifdef HACK_BOOT_CHECKSUM_EN
            csum_q    <= csum_fold(csum_q, rx_data);
`endif
            state     <= ST_DATA_LO;
          end
        end
        ST_DATA_LO: begin
          if (accept) begin
            rom_we    <= 1'b1;
            rom_addr  <= idx_q[ROM_AW-1:0];
            rom_wdata <= {data_hi_q, rx_data};
            idx_q     <= idx_q + (ROM_AW+1)'(1);
`ifdef HACK_BOOT_CHECKSUM_EN
            csum_q    <= csum_fold(csum_q, rx_data);
`endif
            // Release lands in the same cycle as the final write, so the first fetch sees it.
            if (last_word) begin
`ifdef HACK_BOOT_CHECKSUM_EN
              state <= ST_CSUM;
`else
              state     <= ST_RUN;
              boot_done <= 1'b1;
              cpu_reset <= 1'b0;
`endif
            end else begin
              state <= ST_DATA_HI;
            end
          end
        end
`ifdef HACK_BOOT_CHECKSUM_EN
        ST_CSUM: begin
          if (accept) begin
            if (rx_data == csum_q) begin
              state     <= ST_RUN;
              boot_done <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state      <= ST_ERROR;
              boot_error <= 1'b1;
            end
          end
        end
`endif
        ST_RUN, ST_ERROR: begin
          if (reboot) begin
            state      <= ST_LEN_HI;
            idx_q      <= '0;
            cpu_reset  <= 1'b1;
            boot_done  <= 1'b0;
            boot_error <= 1'b0;
`ifdef HACK_BOOT_CHECKSUM_EN
            csum_q     <= '0;
`endif
          end
        end
        default: state <= ST_LEN_HI;
      endcase
    end
  end

endmodule

// File: tb/tb_hack_boot_loader.sv
// Randomized bench for hack_boot_loader with a byte-position reference model.
// Follows HACK_BOOT_CHECKSUM_EN to decide whether images carry a checksum byte.
module tb_hack_boot_loader;
  import hack_boot_pkg::*;

  localparam int ROM_AW = 15;
  localparam int MAX_N  = 1 << ROM_AW;
  localparam int LW     = ROM_AW + 16;
`ifdef HACK_BOOT_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              reboot = 1'b0;
  logic              rx_ready;
  logic              rom_we;
  logic [ROM_AW-1:0] rom_addr;
  logic [15:0]       rom_wdata;
  logic              cpu_reset;
  logic              boot_done;
  logic              boot_error;
  boot_state_e       state_dbg;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  logic [LW-1:0] exp_q[$];
  logic [LW-1:0] got_q[$];
  logic [7:0]    stim_q[$];
  logic [15:0]   word_q[$];

  hack_boot_loader #(.ROM_AW(ROM_AW)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .reboot(reboot), .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
    .cpu_reset(cpu_reset), .boot_done(boot_done), .boot_error(boot_error), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (byte position in stream) ----------------
  int          m_pos, m_n, m_xor;
  logic [7:0]  m_hi;
  bit          m_done, m_err;
  logic        e_we;
  logic [ROM_AW-1:0] e_addr;
  logic [15:0] e_wdata;

  task automatic model_step();
    int p;
    logic [7:0] b;
    e_we = 1'b0;
    if (reset) begin
      m_pos = 0; m_n = 0; m_xor = 0; m_done = 0; m_err = 0;
      e_addr = '0; e_wdata = '0;
    end else if (m_done || m_err) begin
      if (reboot) begin
        m_done = 0; m_err = 0; m_pos = 0; m_xor = 0;
      end
    end else if (rx_valid) begin
      b = rx_data;
      p = m_pos;
      m_pos++;
      if (p == 0) begin
        m_n = int'(b) * 256;
      end else if (p == 1) begin
        m_n += int'(b);
        if (m_n > MAX_N) m_err = 1;
        else if (m_n == 0 && !CSUM_EN) m_done = 1;
      end else if (p < 2 + 2 * m_n) begin
        m_xor ^= int'(b);
        if ((p % 2) == 0) begin
          m_hi = b;
        end else begin
          e_we    = 1'b1;
          e_addr  = ROM_AW'((p - 3) / 2);
          e_wdata = {m_hi, b};
          if (p == 2 * m_n + 1 && !CSUM_EN) m_done = 1;
        end
      end else begin
        if (int'(b) == m_xor) m_done = 1;
        else m_err = 1;
      end
    end
  endtask

  always @(posedge clk) model_step();

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("rx_ready", 32'(rx_ready), 32'(!(m_done || m_err)));
      chk("rom_we", 32'(rom_we), 32'(e_we));
      chk("rom_addr", 32'(rom_addr), 32'(e_addr));
      chk("rom_wdata", 32'(rom_wdata), 32'(e_wdata));
      chk("cpu_reset", 32'(cpu_reset), 32'(!m_done));
      chk("boot_done", 32'(boot_done), 32'(m_done));
      chk("boot_error", 32'(boot_error), 32'(m_err));
      if (rom_we) got_q.push_back({rom_addr, rom_wdata});
    end
  end

  task automatic check_log(input string name);
    chk({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk(name, 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) begin
      rx_data = 8'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit noise);
    bit acc;
    int budget;
    idle(gap);
    rx_valid = 1'b1;
    rx_data  = b;
    reboot   = noise && ($urandom_range(0, 4) == 0);
    budget   = 0;
    do begin
      acc = rx_ready;
      @(negedge clk);
      budget++;
    end while (!acc && budget < 40);
    rx_valid = 1'b0;
    reboot   = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL accept_timeout got no_accept exp accept byte %h", b);
    end
  endtask

  // mode 0: back-to-back, 1: valid one cycle in three, 2: random gaps with reboot noise
  task automatic send_stream(input int mode, input int nbytes);
    int gap;
    for (int i = 0; i < stim_q.size() && (nbytes < 0 || i < nbytes); i++) begin
      gap = (mode == 0) ? 0 : (mode == 1) ? 2 : $urandom_range(0, 3);
      send_byte(stim_q[i], gap, mode == 2);
    end
  endtask

  task automatic build_image(input bit corrupt);
    logic [7:0] x;
    int n;
    n = word_q.size();
    stim_q.delete();
    exp_q.delete();
    x = 8'h00;
    stim_q.push_back(8'(n >> 8));
    stim_q.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      stim_q.push_back(word_q[i][15:8]);
      stim_q.push_back(word_q[i][7:0]);
      x = x ^ word_q[i][15:8] ^ word_q[i][7:0];
      exp_q.push_back({ROM_AW'(i), word_q[i]});
    end
    if (CSUM_EN) stim_q.push_back(corrupt ? (x ^ 8'h01) : x);
  endtask

  task automatic build_len_only(input int n);
    stim_q.delete();
    exp_q.delete();
    stim_q.push_back(8'(n >> 8));
    stim_q.push_back(8'(n));
  endtask

  task automatic random_words(input int n);
    word_q.delete();
    for (int i = 0; i < n; i++) word_q.push_back(16'($urandom));
  endtask

  task automatic pulse_reboot();
    reboot = 1'b1;
    @(negedge clk);
    reboot = 1'b0;
    got_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    got_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    @(negedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("reset_state", 32'(state_dbg), 32'(ST_LEN_HI));
    chk("reset_cpu_reset", 32'(cpu_reset), 32'd1);

    // Two-word image: writes 0:0010, 1:E308, release right after the last byte
    got_q.delete();
    word_q = '{16'h0010, 16'hE308};
    build_image(1'b0);
    send_stream(0, -1);
    chk("img2_boot_done", 32'(boot_done), 32'd1);
    chk("img2_cpu_reset", 32'(cpu_reset), 32'd0);
    idle(1);
    exp_q.delete();
    exp_q.push_back({15'd0, 16'h0010});
    exp_q.push_back({15'd1, 16'hE308});
    check_log("img2_writes");
    pulse_reboot();

`ifdef HACK_BOOT_CHECKSUM_EN
    // Same image, checksum FA instead of FB
    word_q = '{16'h0010, 16'hE308};
    build_image(1'b1);
    chk("bad_csum_last_byte", 32'(stim_q[stim_q.size()-1]), 32'h0000_00FA);
    send_stream(0, -1);
    chk("bad_csum_error", 32'(boot_error), 32'd1);
    chk("bad_csum_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("bad_csum_ready", 32'(rx_ready), 32'd0);
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    repeat (3) @(negedge clk);
    rx_valid = 1'b0;
    pulse_reboot();
    chk("reboot_ready", 32'(rx_ready), 32'd1);
    chk("reboot_state", 32'(state_dbg), 32'(ST_LEN_HI));
`endif

    // Oversized length 32769
    build_len_only(32769);
    send_stream(0, -1);
    chk("oversize_error", 32'(boot_error), 32'd1);
    idle(2);
    chk("oversize_no_writes", 32'(got_q.size()), 32'd0);
    pulse_reboot();

    // Exactly 2**ROM_AW words is legal
    build_len_only(32768);
    send_stream(0, -1);
    chk("max_len_no_error", 32'(boot_error), 32'd0);
    chk("max_len_state", 32'(state_dbg), 32'(ST_DATA_HI));
    do_reset();

    // Empty image
    word_q.delete();
    build_image(1'b0);
    send_stream(0, -1);
    chk("empty_done", 32'(boot_done), 32'd1);
    idle(2);
    chk("empty_no_writes", 32'(got_q.size()), 32'd0);
    pulse_reboot();

    // Four words back-to-back, then again with valid one cycle in three
    random_words(4);
    build_image(1'b0);
    send_stream(0, -1);
    idle(1);
    check_log("four_b2b");
    pulse_reboot();
    send_stream(1, -1);
    idle(1);
    check_log("four_slow");
    pulse_reboot();

    // Reset after three of four words, then a one-word image
    random_words(4);
    build_image(1'b0);
    send_stream(2, 8);
    idle(1);
    do_reset();
    random_words(1);
    build_image(1'b0);
    send_stream(2, -1);
    idle(1);
    check_log("after_reset");
    pulse_reboot();

    // Random images, corrupt checksums and oversized lengths
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 5) == 0) begin
        build_len_only($urandom_range(MAX_N + 1, 65535));
      end else begin
        random_words($urandom_range(0, 6));
        build_image($urandom_range(0, 3) == 0);
      end
      send_stream(2, -1);
      idle($urandom_range(1, 4));
      check_log("random_img");
      pulse_reboot();
    end

    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
